// File: rtl/aes_ctr_din_packer.sv
// ---------------------------------------------------------------------------
// aes_ctr_din_packer
//   Packs a narrow word stream into 128-bit AES blocks for the AES-CTR core's
//   data input. Words fill the block MSB-first. A message that ends mid-block
//   is zero-padded, and its block reports how many bytes are meaningful.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   flush_i        synchronous clear of all held and partial data
//   s_data_i       input word (byte 0 = MSB byte)
//   s_valid_i      input word valid
//   s_last_i       word is the final word of the message
//   s_bytes_i      valid bytes in the final word (1..BW); ignored otherwise
//   s_ready_o      packer accepts a word this cycle
//   blk_o          packed block, first word in the top DATA_W bits
//   blk_valid_o    blk_o valid
//   blk_ready_i    consumer takes the block
//   blk_last_o     block ends the message
//   blk_nbytes_o   valid bytes in blk_o (16 for non-last blocks)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never waits on ready. Once a block is offered, blk_o,
// blk_last_o and blk_nbytes_o hold until it is taken. s_ready_o is
// combinational and never looks at s_valid_i.
// ---------------------------------------------------------------------------
module aes_ctr_din_packer #(
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [DATA_W-1:0]               s_data_i,
    input  logic                            s_valid_i,
    input  logic                            s_last_i,
    input  logic [$clog2(DATA_W/8):0]       s_bytes_i,
    output logic                            s_ready_o,
    output logic [127:0]                    blk_o,
    output logic                            blk_valid_o,
    input  logic                            blk_ready_i,
    output logic                            blk_last_o,
    output logic [4:0]                      blk_nbytes_o
);

    localparam int N     = 128 / DATA_W;
    localparam int BW    = DATA_W / 8;
    localparam int CNT_W = $clog2(N);
    localparam int BYW   = $clog2(BW) + 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [127:0]      asm_q;
    logic              in_fire;
    logic              out_fire;
    logic              blk_done;
    logic [BYW-1:0]    bytes_cl;
    logic [DATA_W-1:0] word_m;
    logic [127:0]      merged;
    logic [4:0]        nbytes_calc;

    // A new word can enter only if the output register is free or is being
    // emptied this very cycle; a flush blocks intake for its cycle.
    assign s_ready_o = !flush_i && (!blk_valid_o || blk_ready_i);
    assign in_fire   = s_valid_i && s_ready_o;
    assign out_fire  = blk_valid_o && blk_ready_i;
    assign blk_done  = in_fire && ((cnt_q == CNT_W'(N - 1)) || s_last_i);

    always_comb begin
        // Out-of-range byte counts are treated as a full word.
        bytes_cl = s_bytes_i;
        if (s_bytes_i == '0 || s_bytes_i > BYW'(BW)) begin
            bytes_cl = BYW'(BW);
        end

        // Blank the trailing bytes of a final word (byte 0 is the MSB byte).
        word_m = s_data_i;
        for (int b = 0; b < BW; b++) begin
            if (s_last_i && (BYW'(b) >= bytes_cl)) begin
                word_m[DATA_W-1-8*b -: 8] = 8'h00;
            end
        end

        // Drop the word into slot cnt. Slots at and above cnt are still
        // zero in asm_q, so unfilled slots come out zero-padded.
        merged = asm_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                merged[127-i*DATA_W -: DATA_W] = word_m;
            end
        end

        nbytes_calc = 5'(cnt_q) * 5'(BW) + 5'(bytes_cl);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            blk_o        <= '0;
            blk_valid_o  <= 1'b0;
            blk_last_o   <= 1'b0;
            blk_nbytes_o <= '0;
        end else if (flush_i) begin
            // blk_o is left as is: it is meaningless while blk_valid_o is low.
            cnt_q        <= '0;
            asm_q        <= '0;
            blk_valid_o  <= 1'b0;
            blk_last_o   <= 1'b0;
            blk_nbytes_o <= '0;
        end else if (blk_done) begin
            // A completing word can coincide with out_fire; valid then stays
            // high and the register picks up the new block (back-to-back).
            blk_o        <= merged;
            blk_valid_o  <= 1'b1;
            blk_last_o   <= s_last_i;
            blk_nbytes_o <= s_last_i ? nbytes_calc : 5'd16;
            cnt_q        <= '0;
            asm_q        <= '0;
        end else begin
            if (out_fire) begin
                blk_valid_o <= 1'b0;
            end
            if (in_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
                asm_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_din_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_ctr_din_packer
//   Self-checking bench for aes_ctr_din_packer with DATA_W=32. A byte-level
//   reference model builds each expected block as words are accepted and
//   pushes it to exp_q. A monitor pops exp_q and compares on every block
//   transfer. Scenario tasks also compare directly against fixed values.
// ---------------------------------------------------------------------------
module tb_aes_ctr_din_packer;

    localparam int DATA_W = 32;
    localparam int N      = 4;
    localparam int BW     = 4;
    localparam int W      = 134;   // {last, nbytes[4:0], blk[127:0]}

    logic         clk;
    logic         rst_n;
    logic         flush_i;
    logic [31:0]  s_data_i;
    logic         s_valid_i;
    logic         s_last_i;
    logic [2:0]   s_bytes_i;
    logic         s_ready_o;
    logic [127:0] blk_o;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic         blk_last_o;
    logic [4:0]   blk_nbytes_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int stall_cnt = 0;

    logic [W-1:0] exp_q[$];
    int           fire_q[$];
    logic [7:0]   mdl_bytes[$];
    int           mdl_words = 0;
    int           mdl_valid = 0;

    logic rand_ready = 1'b0;
    logic rnd_bit    = 1'b1;
    logic ready_ctl  = 1'b1;
    assign blk_ready_i = rand_ready ? rnd_bit : ready_ctl;

    aes_ctr_din_packer #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_bytes_i    (s_bytes_i),
        .s_ready_o    (s_ready_o),
        .blk_o        (blk_o),
        .blk_valid_o  (blk_valid_o),
        .blk_ready_i  (blk_ready_i),
        .blk_last_o   (blk_last_o),
        .blk_nbytes_o (blk_nbytes_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #2 rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // A final word must carry 1..BW valid bytes.
    always @(negedge clk) begin
        if (rst_n && s_valid_i && s_last_i) begin
            assert (s_bytes_i >= 3'd1 && s_bytes_i <= 3'(BW))
                else $error("illegal s_bytes_i %0d on last word", s_bytes_i);
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        mdl_bytes.delete();
        mdl_words = 0;
        mdl_valid = 0;
    endfunction

    function automatic void model_accept(input logic [31:0] d, input logic last,
                                         input logic [2:0] nb);
        int keep;
        logic [127:0] blk;
        keep = last ? int'(nb) : BW;
        for (int b = 0; b < BW; b++) begin
            mdl_bytes.push_back(b < keep ? d[31-8*b -: 8] : 8'h00);
        end
        mdl_valid += keep;
        mdl_words++;
        if (last || mdl_words == N) begin
            blk = '0;
            for (int k = 0; k < 16; k++) begin
                if (k < mdl_bytes.size()) blk[127-8*k -: 8] = mdl_bytes[k];
            end
            exp_q.push_back({last, 5'(last ? mdl_valid : 16), blk});
            model_clear();
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (rst_n && blk_valid_o && blk_ready_i) begin
            fire_q.push_back(cyc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_block: unexpected block got=%h nbytes=%0d last=%0b",
                         blk_o, blk_nbytes_o, blk_last_o);
            end else begin
                exp_v = exp_q.pop_front();
                if ({blk_last_o, blk_nbytes_o, blk_o} !== exp_v) begin
                    n_bad++;
                    $display("FAIL sb_block: got=%h want=%h",
                             {blk_last_o, blk_nbytes_o, blk_o}, exp_v);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        bit done;
        done = 1'b0;
        s_data_i  = d;
        s_last_i  = last;
        s_bytes_i = nb;
        s_valid_i = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (s_ready_o) begin
                done = 1'b1;
                model_accept(d, last, nb);
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted, got ready=0 want 1", d);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_blk(input string name, input logic [127:0] b,
                             input logic last, input logic [4:0] nb);
        @(negedge clk);
        n_cmp++;
        if ({blk_valid_o, blk_last_o, blk_nbytes_o, blk_o} !== {1'b1, last, nb, b}) begin
            n_bad++;
            $display("FAIL %s: got v=%0b l=%0b n=%0d %h want v=1 l=%0b n=%0d %h", name,
                     blk_valid_o, blk_last_o, blk_nbytes_o, blk_o, last, nb, b);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
        s_data_i = '0; s_bytes_i = 3'd4; ready_ctl = 1'b1;
        #12;
        n_cmp++;
        if ({s_ready_o, blk_valid_o, blk_last_o, blk_nbytes_o, blk_o} !== {3'b100, 5'd0, 128'd0}) begin
            n_bad++;
            $display("FAIL reset_values: got rdy=%0b v=%0b l=%0b n=%0d blk=%h want rdy=1 rest 0",
                     s_ready_o, blk_valid_o, blk_last_o, blk_nbytes_o, blk_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_block();
        send_word(32'h00112233, 1'b0, 3'd4);
        send_word(32'h44556677, 1'b0, 3'd4);
        send_word(32'h8899AABB, 1'b0, 3'd4);
        send_word(32'hCCDDEEFF, 1'b1, 3'd4);
        check_blk("full_block", 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 5'd16);
    endtask

    task automatic test_short_last();
        send_word(32'hA0A1A2A3, 1'b0, 3'd4);
        send_word(32'hB0B1B2B3, 1'b0, 3'd4);
        send_word(32'hC0C1C2C3, 1'b1, 3'd2);
        check_blk("short_last", 128'hA0A1A2A3_B0B1B2B3_C0C10000_00000000, 1'b1, 5'd10);
        send_word(32'hDEADBEEF, 1'b1, 3'd1);
        check_blk("one_byte_msg", 128'hDE000000_00000000_00000000_00000000, 1'b1, 5'd1);
    endtask

    task automatic test_back_to_back();
        fire_q.delete();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send_word(32'h10000000 * i + 32'h00010203, (i == 7), 3'd4);
        end
        idle(3);
        n_cmp++;
        if (fire_q.size() != 2 || (fire_q.size() == 2 && fire_q[1] - fire_q[0] != 4)) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d blocks, gap %0d want 2 blocks gap 4",
                     fire_q.size(), fire_q.size() == 2 ? fire_q[1] - fire_q[0] : -1);
        end
        n_cmp++;
        if (stall_cnt != 0) begin
            n_bad++;
            $display("FAIL b2b_ready: got %0d stall cycles want 0", stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        held = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        ready_ctl = 1'b0;
        send_word(32'h01020304, 1'b0, 3'd4);
        send_word(32'h05060708, 1'b0, 3'd4);
        send_word(32'h090A0B0C, 1'b0, 3'd4);
        send_word(32'h0D0E0F10, 1'b0, 3'd4);
        s_data_i = 32'h11111111; s_last_i = 1'b0; s_bytes_i = 3'd4; s_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({s_ready_o, blk_valid_o, blk_o} !== {2'b01, held}) begin
                n_bad++;
                $display("FAIL bp_hold: cyc %0d got rdy=%0b v=%0b blk=%h want rdy=0 v=1 %h",
                         i, s_ready_o, blk_valid_o, blk_o, held);
            end
            @(posedge clk);
            #1;
        end
        ready_ctl = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_ready_o, blk_valid_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL bp_release: got rdy=%0b v=%0b want rdy=1 v=1", s_ready_o, blk_valid_o);
        end
        model_accept(32'h11111111, 1'b0, 3'd4);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        send_word(32'h22222222, 1'b0, 3'd4);
        send_word(32'h33333333, 1'b1, 3'd3);
        check_blk("bp_next", 128'h11111111_22222222_33333300_00000000, 1'b1, 5'd11);
    endtask

    task automatic test_flush();
        send_word(32'hBAD0BAD0, 1'b0, 3'd4);
        send_word(32'hBAD1BAD1, 1'b0, 3'd4);
        flush_i = 1'b1;
        s_data_i = 32'hBAD2BAD2; s_last_i = 1'b1; s_bytes_i = 3'd4; s_valid_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_ready: got %0b want 0", s_ready_o);
        end
        model_clear();
        @(posedge clk);
        #1;
        flush_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
        n_cmp++;
        if ({blk_valid_o, blk_last_o, blk_nbytes_o} !== 7'd0) begin
            n_bad++;
            $display("FAIL flush_clear: got v=%0b l=%0b n=%0d want 0", blk_valid_o, blk_last_o, blk_nbytes_o);
        end
        send_word(32'hF0F1F2F3, 1'b0, 3'd4);
        send_word(32'hF4F5F6F7, 1'b0, 3'd4);
        send_word(32'hF8F9FAFB, 1'b0, 3'd4);
        send_word(32'hFCFDFEFF, 1'b1, 3'd4);
        check_blk("flush_fresh", 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, 1'b1, 5'd16);
    endtask

    task automatic test_async_reset();
        ready_ctl = 1'b0;
        send_word(32'h0BADF00D, 1'b0, 3'd4);
        send_word(32'h1BADF00D, 1'b0, 3'd4);
        send_word(32'h2BADF00D, 1'b0, 3'd4);
        send_word(32'h3BADF00D, 1'b1, 3'd4);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready_o, blk_valid_o, blk_last_o, blk_nbytes_o, blk_o} !== {3'b100, 5'd0, 128'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%0b v=%0b l=%0b n=%0d blk=%h want rdy=1 rest 0",
                     s_ready_o, blk_valid_o, blk_last_o, blk_nbytes_o, blk_o);
        end
        exp_q.delete();
        model_clear();
        ready_ctl = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h55667788, 1'b0, 3'd4);
        send_word(32'h99AABBCC, 1'b1, 3'd4);
        check_blk("after_reset", 128'h55667788_99AABBCC_00000000_00000000, 1'b1, 5'd8);
    endtask

    task automatic test_random();
        int len;
        rand_ready = 1'b1;
        for (int m = 0; m < 8; m++) begin
            len = $urandom_range(1, 9);
            for (int w = 0; w < len; w++) begin
                send_word($urandom, (w == len - 1), 3'($urandom_range(1, 4)));
            end
        end
        rand_ready = 1'b0;
        ready_ctl  = 1'b1;
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d blocks outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_last();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
